// File: rtl/div8by4_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Results appear with a one-cycle done pulse and hold until the next completed operation.
module div8by4_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero,
   output logic [1:0]    dbg_state
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: start is sampled only while IDLE; done is a one-cycle pulse and
   // quotient/remainder/div_by_zero are valid from that cycle until the next done.
   state_t        r_state;
   logic [DW-1:0] r_dreg;
   logic [VW-1:0] r_vreg;
   logic [VW:0]   r_pr;
   logic [DW-1:0] r_qreg;
   logic [CW-1:0] r_cnt;

   logic [VW:0]   w_pr_shift;
   logic          w_ge;
   logic [VW:0]   w_pr_next;
   logic [DW-1:0] w_q_next;
   logic          w_last;

   // Partial remainder stays below the divisor, so the shifted value always fits VW+1 bits.
   assign w_pr_shift = (r_pr << 1) | (VW+1)'(r_dreg[DW-1]);
   assign w_ge       = (w_pr_shift >= {1'b0, r_vreg});
   assign w_pr_next  = w_ge ? (w_pr_shift - {1'b0, r_vreg}) : w_pr_shift;
   assign w_q_next   = (r_qreg << 1) | DW'(w_ge);
   assign w_last     = (r_cnt == CW'(DW - 1));
   assign dbg_state  = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_dreg      <= '0;
         r_vreg      <= '0;
         r_pr        <= '0;
         r_qreg      <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dreg  <= dividend;
                  r_vreg  <= divisor;
                  r_pr    <= '0;
                  r_qreg  <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // A zero divisor spends exactly one RUN cycle, so done arrives one cycle after start.
               if (r_vreg == '0) begin
                  quotient    <= '1;
                  remainder   <= '1;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_pr   <= w_pr_next;
                  r_dreg <= r_dreg << 1;
                  r_qreg <= w_q_next;
                  r_cnt  <= r_cnt + 1'b1;
                  if (w_last) begin
                     quotient    <= w_q_next;
                     remainder   <= w_pr_next[VW-1:0];
                     div_by_zero <= 1'b0;
                     done        <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div8by4_seq.sv
// Directed bench for div8by4_seq: latency, boundaries, divide-by-zero, busy protection,
// mid-operation reset, multiplier-inverse sweep and full dividend/divisor sweep.
module tb_div8by4_seq;

   localparam logic [1:0] ST_IDLE = 2'd0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   div8by4_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one operation, waits (bounded) for done, returns latency and results, ends in IDLE.
   task automatic do_div(input logic [7:0] a, input logic [3:0] b, output int lat,
                         output logic [7:0] q, output logic [3:0] r, output logic dz);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(0, 15));
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      q  = quotient;
      r  = remainder;
      dz = div_by_zero;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: busy/done/dz=%b expected 000", {busy, done, div_by_zero});
      end
      checks++;
      if ({quotient, remainder} !== 12'h000) begin
         errors++;
         $display("FAIL reset_results: q=%0d r=%0d expected 0/0", quotient, remainder);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: state=%0d expected %0d", dbg_state, ST_IDLE);
      end
   endtask

   task automatic test_basic();
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at = -1;
      logic [7:0] q = '0;
      logic [3:0] r = '0;
      logic dz = 1'b1;
      start = 1'b1; dividend = 8'd200; divisor = 4'd13;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
            q = quotient; r = remainder; dz = div_by_zero;
         end
         tick();
      end
      checks++;
      if (busy_cnt !== 9) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d expected 9", busy_cnt);
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 8) begin
         errors++;
         $display("FAIL basic_done_pulse: count=%0d at=%0d expected 1 at 8", done_cnt, done_at);
      end
      checks++;
      if (q !== 8'd15 || r !== 4'd5 || dz !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: q=%0d r=%0d dz=%b expected 15/5/0", q, r, dz);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] ta [4] = '{8'd255, 8'd7, 8'd0, 8'd255};
      logic [3:0] tb [4] = '{4'd1, 4'd9, 4'd5, 4'd15};
      logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd17};
      logic [3:0] er [4] = '{4'd0, 4'd7, 4'd0, 4'd0};
      int lat;
      logic [7:0] q;
      logic [3:0] r;
      logic dz;
      for (int i = 0; i < 4; i++) begin
         do_div(ta[i], tb[i], lat, q, r, dz);
         checks++;
         if (lat !== 8 || q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
            errors++;
            $display("FAIL boundary_%0d/%0d: lat=%0d q=%0d r=%0d dz=%b expected 8/%0d/%0d/0",
                     ta[i], tb[i], lat, q, r, dz, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [7:0] q;
      logic [3:0] r;
      logic dz;
      do_div(8'd42, 4'd0, lat, q, r, dz);
      checks++;
      if (lat !== 1 || q !== 8'hFF || r !== 4'hF || dz !== 1'b1) begin
         errors++;
         $display("FAIL div_zero: lat=%0d q=%h r=%h dz=%b expected 1/ff/f/1", lat, q, r, dz);
      end
      do_div(8'd255, 4'd15, lat, q, r, dz);
      checks++;
      if (lat !== 8 || q !== 8'd17 || r !== 4'd0 || dz !== 1'b0) begin
         errors++;
         $display("FAIL div_zero_clear: lat=%0d q=%0d r=%0d dz=%b expected 8/17/0/0", lat, q, r, dz);
      end
   endtask

   task automatic test_busy_protection();
      int n;
      start = 1'b1; dividend = 8'd100; divisor = 4'd7;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1; dividend = 8'd9; divisor = 4'd3;
      tick();
      start = 1'b0; dividend = 8'd0; divisor = 4'd0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || quotient !== 8'd14 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL busy_first: done=%b q=%0d r=%0d dz=%b expected 1/14/2/0",
                  done, quotient, remainder, div_by_zero);
      end
      start = 1'b1; dividend = 8'd9; divisor = 4'd3;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL busy_done_ignore: done=%b busy=%b state=%0d expected 0/0/%0d",
                  done, busy, dbg_state, ST_IDLE);
      end
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_next_accept: busy=%b expected 1", busy);
      end
      checks++;
      if (quotient !== 8'd14 || remainder !== 4'd2) begin
         errors++;
         $display("FAIL busy_hold: q=%0d r=%0d expected 14/2", quotient, remainder);
      end
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1 || quotient !== 8'd3 || remainder !== 4'd0) begin
         errors++;
         $display("FAIL busy_second: done=%b q=%0d r=%0d expected 1/3/0", done, quotient, remainder);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int done_cnt = 0;
      int lat;
      logic [7:0] q;
      logic [3:0] r;
      logic dz;
      start = 1'b1; dividend = 8'd200; divisor = 4'd13;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_mid_state: busy=%b done=%b q=%0d r=%0d dz=%b state=%0d expected all 0",
                  busy, done, quotient, remainder, div_by_zero, dbg_state);
      end
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) done_cnt++;
         tick();
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d pulses expected 0", done_cnt);
      end
      do_div(8'd50, 4'd6, lat, q, r, dz);
      checks++;
      if (lat !== 8 || q !== 8'd8 || r !== 4'd2 || dz !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_after: lat=%0d q=%0d r=%0d dz=%b expected 8/8/2/0", lat, q, r, dz);
      end
   endtask

   task automatic test_inverse();
      int lat;
      logic [7:0] q;
      logic [3:0] r;
      logic dz;
      logic [7:0] p;
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            p = 8'(a * b);
            do_div(p, 4'(b), lat, q, r, dz);
            checks++;
            if (q !== 8'(a) || r !== 4'd0 || dz !== 1'b0 || lat !== 8) begin
               errors++;
               $display("FAIL inverse_%0dx%0d: q=%0d r=%0d dz=%b lat=%0d expected %0d/0/0/8",
                        a, b, q, r, dz, lat, a);
            end
         end
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [7:0] q;
      logic [3:0] r;
      logic dz;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            do_div(8'(a), 4'(b), lat, q, r, dz);
            checks++;
            if (q !== 8'(a / b) || r !== 4'(a % b) || dz !== 1'b0 ||
                (int'(q) * b + int'(r)) != a || int'(r) >= b) begin
               errors++;
               $display("FAIL sweep_%0d/%0d: q=%0d r=%0d dz=%b expected %0d/%0d/0",
                        a, b, q, r, dz, a / b, a % b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_busy_protection();
      test_reset_mid();
      test_inverse();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
